// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and saturation constants for the sequential
// signed divider.
package div_pkg;

  localparam int DIV_W    = 16;
  localparam int DIV_ITER = 16;
  localparam int DIV_LAT  = 18;
  localparam int CNT_W    = $clog2(DIV_ITER);

  localparam logic [DIV_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DIV_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // |0x8000| wraps to 0x8000, which is the correct unsigned magnitude
  function automatic logic [DIV_W-1:0] abs_w(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div16_seq_if.sv
// Start/operand/result bundle between the execute-stage pipeline and the
// divider. clk/rst stay outside as plain ports.
interface div16_seq_if;
  import div_pkg::*;

  logic             start;
  logic [DIV_W-1:0] a;
  logic [DIV_W-1:0] b;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quot;
  logic [DIV_W-1:0] rem;
  logic             dbz;
  logic             ovfl;

  modport master (
    output start, a, b,
    input  busy, done, quot, rem, dbz, ovfl
  );

  modport slave (
    input  start, a, b,
    output busy, done, quot, rem, dbz, ovfl
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor magnitude, keep or restore.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W:0]   prem_i,
  input  logic             din_i,
  input  logic [DIV_W-1:0] dvsr_i,
  output logic [DIV_W:0]   prem_o,
  output logic             qbit_o
);

  logic [DIV_W+1:0] shifted;
  logic [DIV_W:0]   diff;

  always_comb begin
    shifted = {prem_i, din_i};
    // Partial remainder stays below |b| <= 0x8000, so shifted fits 17 bits
    qbit_o  = (shifted >= {2'b00, dvsr_i});
    diff    = shifted[DIV_W:0] - {1'b0, dvsr_i};
    prem_o  = qbit_o ? diff : shifted[DIV_W:0];
  end

endmodule

// File: rtl/div16_seq.sv
// Sequential 16-bit signed restoring divider, fixed 18-cycle latency.
// Define DIV_SAT_EN for saturating overflow/divide-by-zero results.
module div16_seq
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  div16_seq_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   prem_q, prem_d;
  logic [DIV_W-1:0] dq_q, dq_d;       // dividend magnitude in, quotient out
  logic [DIV_W-1:0] bmag_q, bmag_d;
  logic [DIV_W-1:0] a_q, a_d;
  logic             sa_q, sa_d;
  logic             sq_q, sq_d;
  logic             dbz_p_q, dbz_p_d;
  logic             ovfl_p_q, ovfl_p_d;
  logic [DIV_W-1:0] quot_q, quot_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovfl_q, ovfl_d;

  logic [DIV_W:0]   prem_nxt;
  logic             qbit;
  logic             accept;
  logic [DIV_W-1:0] q_fix, r_fix;

  div_step u_step (
    .prem_i (prem_q),
    .din_i  (dq_q[DIV_W-1]),
    .dvsr_i (bmag_q),
    .prem_o (prem_nxt),
    .qbit_o (qbit)
  );

  assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign bus.busy = (state_q == CALC) || (state_q == FIX);
  assign bus.done = (state_q == DONE);
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.dbz  = dbz_q;
  assign bus.ovfl = ovfl_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prem_d   = prem_q;
    dq_d     = dq_q;
    bmag_d   = bmag_q;
    a_d      = a_q;
    sa_d     = sa_q;
    sq_d     = sq_q;
    dbz_p_d  = dbz_p_q;
    ovfl_p_d = ovfl_p_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    ovfl_d   = ovfl_q;
    q_fix    = sq_q ? (~dq_q + 1'b1) : dq_q;
    r_fix    = sa_q ? (~prem_q[DIV_W-1:0] + 1'b1) : prem_q[DIV_W-1:0];

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d  = CALC;
          cnt_d    = '0;
          prem_d   = '0;
          dq_d     = abs_w(bus.a);
          bmag_d   = abs_w(bus.b);
          a_d      = bus.a;
          sa_d     = bus.a[DIV_W-1];
          sq_d     = bus.a[DIV_W-1] ^ bus.b[DIV_W-1];
          dbz_p_d  = (bus.b == '0);
          ovfl_p_d = (bus.a == SAT_MIN) && (bus.b == '1);
        end
      end
      CALC: begin
        prem_d = prem_nxt;
        dq_d   = {dq_q[DIV_W-2:0], qbit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        quot_d  = q_fix;
        rem_d   = r_fix;
        dbz_d   = dbz_p_q;
        ovfl_d  = ovfl_p_q;
        // Special cases still take the full latency so stall timing is uniform
`ifdef DIV_SAT_EN
        if (ovfl_p_q) begin
          quot_d = SAT_MAX;
          rem_d  = '0;
        end else if (dbz_p_q) begin
          quot_d = a_q[DIV_W-1] ? SAT_MIN : SAT_MAX;
          rem_d  = a_q;
        end
`else
        if (ovfl_p_q) begin
          quot_d = SAT_MIN;
          rem_d  = '0;
        end else if (dbz_p_q) begin
          quot_d = '1;
          rem_d  = a_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prem_q   <= '0;
      dq_q     <= '0;
      bmag_q   <= '0;
      a_q      <= '0;
      sa_q     <= 1'b0;
      sq_q     <= 1'b0;
      dbz_p_q  <= 1'b0;
      ovfl_p_q <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      ovfl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prem_q   <= prem_d;
      dq_q     <= dq_d;
      bmag_q   <= bmag_d;
      a_q      <= a_d;
      sa_q     <= sa_d;
      sq_q     <= sq_d;
      dbz_p_q  <= dbz_p_d;
      ovfl_p_q <= ovfl_p_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      ovfl_q   <= ovfl_d;
    end
  end

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq against an integer-arithmetic reference.
module tb_div16_seq;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div16_seq_if bus();

  div16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [33:0] last_exp = '0;   // {quot, rem, dbz, ovfl} currently expected on the outputs

  function automatic logic [33:0] model(input logic [15:0] a, input logic [15:0] b);
    int sa, sb, q, r;
    logic [15:0] q16, r16;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
`ifdef DIV_SAT_EN
      q16 = (sa >= 0) ? 16'h7FFF : 16'h8000;
`else
      q16 = 16'hFFFF;
`endif
      return {q16, a, 1'b1, 1'b0};
    end
    if (sa == -32768 && sb == -1) begin
`ifdef DIV_SAT_EN
      q16 = 16'h7FFF;
`else
      q16 = 16'h8000;
`endif
      return {q16, 16'h0000, 1'b0, 1'b1};
    end
    q = sa / sb;
    r = sa % sb;
    q16 = 16'(q);
    r16 = 16'(r);
    return {q16, r16, 1'b0, 1'b0};
  endfunction

  // Starts a divide in the current cycle, optionally pulses an ignored start
  // with 9/3 at cycle inj, checks busy/done per cycle, results at cycle 18.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int inj, input string tag);
    logic [33:0] exp;
    exp = model(a, b);
    bus.start = 1'b1; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c == inj) begin
        bus.start = 1'b1; bus.a = 16'd9; bus.b = 16'd3;
      end
      n_chk++;
      if ({bus.busy, bus.done} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s busy/done cyc %0d: got %b want 10", tag, c, {bus.busy, bus.done});
      end
      n_chk++;
      if ({bus.quot, bus.rem, bus.dbz, bus.ovfl} !== last_exp) begin
        n_fail++;
        $display("FAIL %s held results cyc %0d: got %h want %h", tag, c,
                 {bus.quot, bus.rem, bus.dbz, bus.ovfl}, last_exp);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s busy/done cyc 18: got %b want 01", tag, {bus.busy, bus.done});
    end
    n_chk++;
    if ({bus.quot, bus.rem, bus.dbz, bus.ovfl} !== exp) begin
      n_fail++;
      $display("FAIL %s result a=%h b=%h: got q=%h r=%h dbz=%b ovfl=%b want q=%h r=%h dbz=%b ovfl=%b",
               tag, a, b, bus.quot, bus.rem, bus.dbz, bus.ovfl,
               exp[33:18], exp[17:2], exp[1], exp[0]);
    end
    last_exp = exp;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s idle busy/done: got %b want 00", tag, {bus.busy, bus.done});
    end
  endtask

  task automatic check_zero(input string tag);
    n_chk++;
    if ({bus.busy, bus.done, bus.quot, bus.rem, bus.dbz, bus.ovfl} !== 36'h0) begin
      n_fail++;
      $display("FAIL %s reset outputs: got busy=%b done=%b q=%h r=%h dbz=%b ovfl=%b want all 0",
               tag, bus.busy, bus.done, bus.quot, bus.rem, bus.dbz, bus.ovfl);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");
    idle_cycle("reset");
    last_exp = '0;
  endtask

  task automatic test_directed();
    run_div(16'd100, 16'd7, 0, "100/7");
    idle_cycle("100/7");
    run_div(16'hFF9C, 16'd7, 0, "-100/7");
    run_div(16'd100, 16'hFFF9, 0, "100/-7");
    run_div(16'hFF9C, 16'hFFF9, 0, "-100/-7");
    run_div(16'd3, 16'd7, 0, "3/7");
    idle_cycle("directed");
  endtask

  task automatic test_dbz();
    run_div(16'd5, 16'd0, 0, "5/0");
    run_div(16'hFFFB, 16'd0, 0, "-5/0");
    run_div(16'd0, 16'd0, 0, "0/0");
    idle_cycle("dbz");
  endtask

  task automatic test_ovfl();
    run_div(16'h8000, 16'hFFFF, 0, "min/-1");
    run_div(16'h8000, 16'd1, 0, "min/1");
    run_div(16'h8000, 16'h8000, 0, "min/min");
    run_div(16'd7, 16'h8000, 0, "7/min");
    run_div(16'h7FFF, 16'hFFFF, 0, "max/-1");
    idle_cycle("ovfl");
  endtask

  task automatic test_back_to_back();
    run_div(16'd100, 16'd7, 5, "busy-start");
    run_div(16'd9, 16'd3, 0, "start-in-done");
    run_div(16'd1000, 16'd33, 0, "start-in-done2");
    idle_cycle("b2b");
  endtask

  task automatic test_rst_abort();
    bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_exp = '0;
    check_zero("rst-abort");
    for (int c = 10; c <= 30; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst-abort busy/done cyc %0d: got %b want 00", c, {bus.busy, bus.done});
      end
    end
    run_div(16'd50, 16'd6, 0, "post-rst");
    rst = 1'b1; bus.start = 1'b1; bus.a = 16'd9; bus.b = 16'd3;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    last_exp = '0;
    check_zero("rst+start");
    for (int c = 0; c < 3; c++) idle_cycle("rst+start");
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom_range(0, 15));
        1:       rb = 16'(-$signed(17'($urandom_range(1, 15))));
        default: rb = 16'($urandom);
      endcase
      run_div(ra, rb, 0, "random");
      if ($urandom_range(0, 1) == 1) idle_cycle("random");
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_directed();
    test_dbz();
    test_ovfl();
    test_back_to_back();
    test_rst_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
